// File: rtl/pe_pkg.sv
// Shared types, default widths and arithmetic helpers for the systolic PE family.
package pe_pkg;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ACCUM_WIDTH_DEF = 32;
  localparam int MAX_W           = 64;

  typedef logic [0:0] pe_state_t;
  localparam pe_state_t IDLE  = 1'b0;
  localparam pe_state_t ACCUM = 1'b1;

  typedef logic [MAX_W-1:0] word_t;
  typedef struct packed {
    logic  sat;
    word_t sum;
  } sat_sum_t;

  // dw-bit operands, sign- or zero-extended; the product is exact modulo 2^MAX_W.
  function automatic word_t ext_mul(word_t a, word_t b, int unsigned dw, logic sgn);
    word_t mask, ax, bx;
    mask = (word_t'(1) << dw) - word_t'(1);
    ax   = a & mask;
    bx   = b & mask;
    if (sgn && a[6'(dw - 1)]) ax = ax | ~mask;
    if (sgn && b[6'(dw - 1)]) bx = bx | ~mask;
    return ax * bx;
  endfunction

  // aw-bit add clamped to the signed or unsigned aw-bit range.
  function automatic sat_sum_t sat_add(word_t a, word_t b, int unsigned aw, logic sgn);
    logic signed [MAX_W+1:0] one, ax, bx, sum, max_v, min_v;
    word_t    mask;
    sat_sum_t r;
    one   = 1;
    mask  = (word_t'(1) << aw) - word_t'(1);
    ax    = {2'b00, a & mask};
    bx    = {2'b00, b & mask};
    if (sgn && a[6'(aw - 1)]) ax = ax - (one << aw);
    if (sgn && b[6'(aw - 1)]) bx = bx - (one << aw);
    max_v = sgn ? (one << (aw - 1)) - one : (one << aw) - one;
    min_v = sgn ? -(one << (aw - 1)) : '0;
    sum   = ax + bx;
    r.sat = 1'b0;
    r.sum = word_t'(sum);
    if (sum > max_v) begin
      r.sum = word_t'(max_v);
      r.sat = 1'b1;
    end else if (sum < min_v) begin
      r.sum = word_t'(min_v);
      r.sat = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/pe_result_slot.sv
// One-entry valid/ready result register with sticky overflow; PE_MAC_SAT_EN adds a per-result sat_flag.
module pe_result_slot
  import pe_pkg::*;
#(
  parameter int WIDTH = ACCUM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef PE_MAC_SAT_EN
  input  logic             load_sat,
  output logic             sat_flag,
`endif
  input  logic             rdy,
  output logic [WIDTH-1:0] result,
  output logic             vld,
  output logic             err_ovf
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is a single register, not a RAM, so it is reset and reads 0 afterwards.
      result   <= '0;
      vld      <= 1'b0;
      err_ovf  <= 1'b0;
`ifdef PE_MAC_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (load) begin
      if (!vld || rdy) begin
        result   <= load_value;
        vld      <= 1'b1;
`ifdef PE_MAC_SAT_EN
        sat_flag <= load_sat;
`endif
      end else begin
        err_ovf <= 1'b1;
      end
    end else if (rdy) begin
      vld <= 1'b0;
    end
  end
endmodule

// File: rtl/pe_mac_stream.sv
// Output-stationary systolic PE: registered forwarding, valid/last-qualified MAC, drained result slot.
// Optional PE_MAC_SAT_EN: saturating accumulate and a sat_flag output.
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int MUL_STAGES  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   accum_reset,
  input  logic                   op_signed,
  input  logic [DATA_WIDTH-1:0]  in_north,
  input  logic                   in_north_vld,
  input  logic [DATA_WIDTH-1:0]  in_west,
  input  logic                   in_west_vld,
  input  logic                   in_west_last,
  output logic [DATA_WIDTH-1:0]  out_south,
  output logic                   out_south_vld,
  output logic [DATA_WIDTH-1:0]  out_east,
  output logic                   out_east_vld,
  output logic                   out_east_last,
  output logic [ACCUM_WIDTH-1:0] result,
  output logic                   result_vld,
  input  logic                   result_rdy,
  output logic                   err_ovf
`ifdef PE_MAC_SAT_EN
  ,
  output logic                   sat_flag
`endif
);
  logic                   fire_now, step_fire, step_last, load;
  logic [ACCUM_WIDTH-1:0] prod_now, step_prod, acc, acc_sum, tile_sum;
  pe_state_t              state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_south     <= '0;
      out_south_vld <= 1'b0;
      out_east      <= '0;
      out_east_vld  <= 1'b0;
      out_east_last <= 1'b0;
    end else if (en) begin
      // NOTE: registers use <= so every stage samples pre-edge values regardless of block order.
      out_south     <= in_north;
      out_south_vld <= in_north_vld;
      out_east      <= in_west;
      out_east_vld  <= in_west_vld;
      out_east_last <= in_west_last;
    end
  end

  assign fire_now = en & in_north_vld & in_west_vld;
  assign prod_now = ACCUM_WIDTH'(ext_mul(word_t'(in_north), word_t'(in_west), DATA_WIDTH, op_signed));

  if (MUL_STAGES == 0) begin : g_comb
    assign step_fire = fire_now;
    assign step_last = in_west_last;
    assign step_prod = prod_now;
  end else begin : g_pipe
    logic                   p_fire, p_last;
    logic [ACCUM_WIDTH-1:0] p_prod;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_fire <= 1'b0;
        p_last <= 1'b0;
        p_prod <= '0;
      end else if (en) begin
        if (accum_reset) begin
          p_fire <= 1'b0;
          p_last <= 1'b0;
        end else begin
          p_fire <= fire_now;
          p_last <= in_west_last;
          p_prod <= prod_now;
        end
      end
    end
    // A frozen pipeline must not accumulate its held product again.
    assign step_fire = en & p_fire;
    assign step_last = p_last;
    assign step_prod = p_prod;
  end

`ifdef PE_MAC_SAT_EN
  sat_sum_t add_r;
  logic     add_sat, tile_sat, load_sat;
  assign add_r    = sat_add(word_t'(acc), word_t'(step_prod), ACCUM_WIDTH, op_signed);
  assign acc_sum  = ACCUM_WIDTH'(add_r.sum);
  assign add_sat  = (state == ACCUM) & add_r.sat;
  assign load_sat = tile_sat | add_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tile_sat <= 1'b0;
    else if (en && accum_reset)  tile_sat <= 1'b0;
    else if (step_fire)          tile_sat <= step_last ? 1'b0 : load_sat;
  end
`else
  assign acc_sum = acc + step_prod;
`endif

  // The first element of a tile replaces the stale accumulator, so no clear cycle is needed.
  assign tile_sum = (state == IDLE) ? step_prod : acc_sum;
  assign load     = step_fire & step_last & ~accum_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
    end else if (en && accum_reset) begin
      state <= IDLE;
      acc   <= '0;
    end else if (step_fire) begin
      if (step_last) begin
        state <= IDLE;
      end else begin
        state <= ACCUM;
        acc   <= tile_sum;
      end
    end
  end

  pe_result_slot #(.WIDTH(ACCUM_WIDTH)) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (tile_sum),
`ifdef PE_MAC_SAT_EN
    .load_sat   (load_sat),
    .sat_flag   (sat_flag),
`endif
    .rdy        (result_rdy),
    .result     (result),
    .vld        (result_vld),
    .err_ovf    (err_ovf)
  );
endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench: three PE variants (MUL_STAGES 0/1, 16-bit accumulator) against a tile-level model.
module tb_pe_mac_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, accum_reset, op_signed, n_vld, w_vld, w_last, rdy;
  logic [7:0] n_data, w_data;

  logic [7:0]  south [3], east [3];
  logic        south_vld [3], east_vld [3], east_last [3], rv [3], err [3];
  logic [31:0] res0, res1;
  logic [15:0] res2;
`ifdef PE_MAC_SAT_EN
  logic        satf [3];
`endif

  pe_mac_stream #(.DATA_WIDTH(8), .ACCUM_WIDTH(32), .MUL_STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .accum_reset(accum_reset), .op_signed(op_signed),
    .in_north(n_data), .in_north_vld(n_vld), .in_west(w_data), .in_west_vld(w_vld),
    .in_west_last(w_last), .out_south(south[0]), .out_south_vld(south_vld[0]),
    .out_east(east[0]), .out_east_vld(east_vld[0]), .out_east_last(east_last[0]),
    .result(res0), .result_vld(rv[0]), .result_rdy(rdy), .err_ovf(err[0])
`ifdef PE_MAC_SAT_EN
    , .sat_flag(satf[0])
`endif
  );

  pe_mac_stream #(.DATA_WIDTH(8), .ACCUM_WIDTH(32), .MUL_STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .accum_reset(accum_reset), .op_signed(op_signed),
    .in_north(n_data), .in_north_vld(n_vld), .in_west(w_data), .in_west_vld(w_vld),
    .in_west_last(w_last), .out_south(south[1]), .out_south_vld(south_vld[1]),
    .out_east(east[1]), .out_east_vld(east_vld[1]), .out_east_last(east_last[1]),
    .result(res1), .result_vld(rv[1]), .result_rdy(rdy), .err_ovf(err[1])
`ifdef PE_MAC_SAT_EN
    , .sat_flag(satf[1])
`endif
  );

  pe_mac_stream #(.DATA_WIDTH(8), .ACCUM_WIDTH(16), .MUL_STAGES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .accum_reset(accum_reset), .op_signed(op_signed),
    .in_north(n_data), .in_north_vld(n_vld), .in_west(w_data), .in_west_vld(w_vld),
    .in_west_last(w_last), .out_south(south[2]), .out_south_vld(south_vld[2]),
    .out_east(east[2]), .out_east_vld(east_vld[2]), .out_east_last(east_last[2]),
    .result(res2), .result_vld(rv[2]), .result_rdy(rdy), .err_ovf(err[2])
`ifdef PE_MAC_SAT_EN
    , .sat_flag(satf[2])
`endif
  );

  // Reference model: tile sums as plain integers, a delay slot per pipelined variant.
  int     aw_of [3] = '{32, 32, 16};
  int     ms_of [3] = '{0, 1, 0};
  longint m_acc [3], pd_p [3], s_res [3];
  bit     m_busy [3], m_tsat [3], pd_v [3], pd_l [3], s_vld [3], s_err [3], s_sat [3];
  logic [7:0] f_s, f_e;
  bit     f_sv, f_ev, f_el;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int aw, input bit sgn);
    longint m, r;
    m = longint'(1) << aw;
    r = v % m;
    if (r < 0) r += m;
    if (sgn && r >= (m >> 1)) r -= m;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_busy[i] = 0; m_tsat[i] = 0;
      pd_v[i] = 0; pd_p[i] = 0; pd_l[i] = 0;
      s_vld[i] = 0; s_res[i] = 0; s_err[i] = 0; s_sat[i] = 0;
    end
    f_s = 0; f_e = 0; f_sv = 0; f_ev = 0; f_el = 0;
  endtask

  task automatic model_step();
    longint prod, sp, val, lo, hi;
    bit     sf, sl, ld, ldsat, sat;
    int     aw;
    if (op_signed) prod = longint'($signed(n_data)) * longint'($signed(w_data));
    else           prod = longint'(n_data) * longint'(w_data);
    for (int i = 0; i < 3; i++) begin
      aw = aw_of[i]; ld = 0; ldsat = 0; val = 0;
      if (en) begin
        if (accum_reset) begin
          m_acc[i] = 0; m_busy[i] = 0; m_tsat[i] = 0; pd_v[i] = 0;
        end else begin
          if (ms_of[i] == 0) begin
            sf = n_vld && w_vld; sp = prod; sl = w_last;
          end else begin
            sf = pd_v[i]; sp = pd_p[i]; sl = pd_l[i];
            pd_v[i] = n_vld && w_vld; pd_p[i] = prod; pd_l[i] = w_last;
          end
          if (sf) begin
            sat = 0;
            if (!m_busy[i]) begin
              val = sp;
            end else begin
              val = m_acc[i] + sp;
`ifdef PE_MAC_SAT_EN
              hi = op_signed ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
              lo = op_signed ? -(longint'(1) << (aw - 1)) : 0;
              if (val > hi) begin val = hi; sat = 1; end
              else if (val < lo) begin val = lo; sat = 1; end
`else
              val = wrap(val, aw, op_signed);
`endif
            end
            if (sl) begin
              ld = 1; ldsat = m_busy[i] && (m_tsat[i] || sat);
              m_busy[i] = 0; m_tsat[i] = 0;
            end else begin
              m_tsat[i] = m_busy[i] ? (m_tsat[i] || sat) : 0;
              m_acc[i] = val; m_busy[i] = 1;
            end
          end
        end
      end
      if (ld) begin
        if (!s_vld[i] || rdy) begin
          s_vld[i] = 1; s_res[i] = val; s_sat[i] = ldsat;
        end else begin
          s_err[i] = 1;
        end
      end else if (rdy) begin
        s_vld[i] = 0;
      end
    end
    if (en) begin
      f_s = n_data; f_sv = n_vld; f_e = w_data; f_ev = w_vld; f_el = w_last;
    end
  endtask

  function automatic logic [63:0] res_of(input int i);
    case (i)
      0:       return 64'(res0);
      1:       return 64'(res1);
      default: return 64'(res2);
    endcase
  endfunction

  task automatic compare_all(input string tag);
    logic [63:0] mask;
    for (int i = 0; i < 3; i++) begin
      mask = (64'd1 << aw_of[i]) - 64'd1;
      check($sformatf("%s_d%0d_vld", tag, i), rv[i], s_vld[i]);
      check($sformatf("%s_d%0d_res", tag, i), res_of(i), 64'(s_res[i]) & mask);
      check($sformatf("%s_d%0d_err", tag, i), err[i], s_err[i]);
`ifdef PE_MAC_SAT_EN
      check($sformatf("%s_d%0d_sat", tag, i), satf[i], s_sat[i]);
`endif
      check($sformatf("%s_d%0d_south", tag, i), {south_vld[i], south[i]}, {f_sv, f_s});
      check($sformatf("%s_d%0d_east", tag, i), {east_last[i], east_vld[i], east[i]}, {f_el, f_ev, f_e});
    end
  endtask

  task automatic drive(input bit e, input bit nv, input logic [7:0] n, input bit wv,
                       input logic [7:0] w, input bit wl);
    en = e; n_vld = nv; n_data = n; w_vld = wv; w_data = w; w_last = wl;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic fire(input logic [7:0] n, input logic [7:0] w, input bit last, input string tag);
    drive(1, 1, n, 1, w, last);
    cyc(tag);
  endtask

  task automatic idle(input string tag);
    drive(1, 0, 8'($urandom), 0, 8'($urandom), 0);
    cyc(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; accum_reset = 0; op_signed = 1; rdy = 0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_res0", res0, 0);
    check("reset_vld0", rv[0], 0);
    compare_all("reset");
    @(negedge clk);
    rst_n = 1;

    // Signed 4-element tile: 12 - 10 - 7 + 16384.
    op_signed = 1;
    fire(8'd3, 8'd4, 0, "t1");
    fire(8'hFE, 8'd5, 0, "t1");
    fire(8'd7, 8'hFF, 0, "t1");
    fire(8'h80, 8'h80, 1, "t1");
    check("t1_d0_result", res0, 16379);
    check("t1_d0_vld", rv[0], 1);
    check("t1_d1_not_yet", rv[1], 0);
    idle("t1");
    check("t1_d1_result", res1, 16379);
    check("t1_d1_vld", rv[1], 1);
    rdy = 1; idle("t1_drain"); rdy = 0;

    // Unsigned single-element tile, then a fresh tile proving IDLE was kept.
    op_signed = 0;
    fire(8'hFF, 8'hFF, 1, "t2");
    check("t2_d0_result", res0, 65025);
    check("t2_d2_result", res2, 16'hFE01);
    rdy = 1; idle("t2_drain"); rdy = 0;
    fire(8'd2, 8'd3, 0, "t2b");
    fire(8'd1, 8'd1, 1, "t2b");
    check("t2b_d0_result", res0, 7);
    rdy = 1; idle("t2b_drain"); idle("t2b_drain"); rdy = 0;

    // Back-to-back tiles with the slot stalled, then a same-cycle replace.
    op_signed = 1;
    fire(8'd1, 8'd4, 0, "t3");
    fire(8'd2, 8'd3, 1, "t3");
    fire(8'd4, 8'd5, 1, "t3");
    idle("t3"); idle("t3");
    check("t3_d0_keep", res0, 10);
    check("t3_d1_keep", res1, 10);
    check("t3_d0_err", err[0], 1);
    check("t3_d1_err", err[1], 1);
    rdy = 1;
    fire(8'd5, 8'd1, 1, "t3c");
    check("t3c_d0_result", res0, 5);
    check("t3c_d0_vld", rv[0], 1);
    idle("t3c");
    check("t3c_d1_result", res1, 5);
    idle("t3c_drain");
    rdy = 0;

    // Frozen pipeline with en=0, valid gaps, then accum_reset between tiles.
    op_signed = 0;
    fire(8'd3, 8'd3, 0, "t4");
    fire(8'd2, 8'd2, 0, "t4");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 8'($urandom), 1, 8'($urandom), 1);
      cyc("t4_frz");
    end
    idle("t4");
    fire(8'd1, 8'd1, 1, "t4");
    idle("t4");
    check("t4_d0_result", res0, 14);
    check("t4_d1_result", res1, 14);
    fire(8'd9, 8'd9, 0, "t4r");
    accum_reset = 1;
    fire(8'd4, 8'd4, 0, "t4r");
    accum_reset = 0;
    check("t4r_d0_slot_kept", res0, 14);
    check("t4r_d0_vld_kept", rv[0], 1);
    rdy = 1; idle("t4_drain"); rdy = 0;
    fire(8'd1, 8'd2, 1, "t4s");
    idle("t4s");
    check("t4s_d0_result", res0, 2);
    check("t4s_d1_result", res1, 2);
    rdy = 1; idle("t4_drain"); idle("t4_drain"); rdy = 0;

    // Asynchronous reset between edges in the middle of a tile.
    fire(8'd7, 8'd7, 0, "t5");
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t5_rst_res0", res0, 0);
    check("t5_rst_err0", err[0], 0);
    check("t5_rst_south0", south[0], 0);
    compare_all("t5_rst");
    drive(1, 1, 8'd1, 1, 8'd3, 1);
    #1 rst_n = 1;
    cyc("t5");
    idle("t5");
    check("t5_d0_result", res0, 3);
    check("t5_d1_result", res1, 3);
    rdy = 1; idle("t5_drain"); idle("t5_drain"); rdy = 0;

    // Three 127*127 products overflow a signed 16-bit accumulator.
    op_signed = 1;
    fire(8'd127, 8'd127, 0, "t6");
    fire(8'd127, 8'd127, 0, "t6");
    fire(8'd127, 8'd127, 1, "t6");
    check("t6_d0_result", res0, 48387);
`ifdef PE_MAC_SAT_EN
    check("t6_d2_result", res2, 16'h7FFF);
    check("t6_d2_sat", satf[2], 1);
    check("t6_d0_sat", satf[0], 0);
`else
    check("t6_d2_result", res2, 16'hBD03);
`endif
    rdy = 1; idle("t6_drain"); idle("t6_drain"); rdy = 0;

    // Random traffic; signedness changes only across an accum_reset.
    for (int blk = 0; blk < 4; blk++) begin
      op_signed = blk[0];
      accum_reset = 1;
      idle("rnd_clr");
      accum_reset = 0;
      for (int k = 0; k < 100; k++) begin
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
        accum_reset = $urandom_range(0, 49) == 0;
        rdy = $urandom_range(0, 1) == 1;
        cyc("rnd");
      end
      accum_reset = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
